sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 18 +
 rtl/sram_arbiter_rr_arb2.sv | 38 +++
 rtl/sram_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the two-master SRAM arbiter.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  typedef enum logic {
    OwnInst = 1'b0,
    OwnData = 1'b1
  } owner_e;

  localparam int unsigned AwDefault = 32;
  localparam int unsigned DwDefault = 32;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-input round-robin grant; the last granted owner loses the next tie.
module rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_req_inst,
  input  logic   i_req_data,
  input  logic   i_take,
  output logic   o_valid,
  output owner_e o_owner
);

  owner_e r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= OwnInst;
    end else if (i_take && o_valid) begin
      r_last <= o_owner;
    end
  end

  always_comb begin
    o_valid = i_req_inst | i_req_data;
    o_owner = OwnInst;
    if (i_req_inst && i_req_data) begin
      if (r_last == OwnInst) begin
        o_owner = OwnData;
      end else begin
        o_owner = OwnInst;
      end
    end else if (i_req_data) begin
      o_owner = OwnData;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one SRAM-like port,
// one transaction outstanding at a time.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned DW = DwDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  input  logic            inst_cancel,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [DW-1:0]   inst_rdata,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [DW-1:0]   data_rdata,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata
);

  state_e            r_state, w_state_next;
  owner_e            r_owner;
  logic              r_wr;
  logic [DW/8-1:0]   r_wstrb;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic              r_cancelled;

  logic              w_grant_valid;
  owner_e            w_grant_owner;
  logic              w_take;
  logic              w_resp;

  assign w_take = (r_state == StIdle) && w_grant_valid;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .reset      (reset),
    .i_req_inst (inst_req),
    .i_req_data (data_req),
    .i_take     (w_take),
    .o_valid    (w_grant_valid),
    .o_owner    (w_grant_owner)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_grant_valid) w_state_next = StAddr;
      StAddr:  if (mem_addr_ok)   w_state_next = StData;
      StData:  if (mem_data_ok)   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    inst_addr_ok = w_take && (w_grant_owner == OwnInst);
    data_addr_ok = w_take && (w_grant_owner == OwnData);
    mem_req      = (r_state == StAddr);
    mem_wr       = r_wr;
    mem_wstrb    = r_wstrb;
    mem_addr     = r_addr;
    mem_wdata    = r_wdata;
    w_resp       = (r_state == StData) && mem_data_ok;
    // A cancel arriving with the response still kills the fetch data.
    inst_data_ok = w_resp && (r_owner == OwnInst) && !r_cancelled && !inst_cancel;
    data_data_ok = w_resp && (r_owner == OwnData);
    inst_rdata   = inst_data_ok ? mem_rdata : '0;
    data_rdata   = data_data_ok ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_owner     <= OwnInst;
      r_wr        <= 1'b0;
      r_wstrb     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cancelled <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_owner <= w_grant_owner;
        if (w_grant_owner == OwnData) begin
          r_wr    <= data_wr;
          r_wstrb <= data_wr ? data_wstrb : '0;
          r_addr  <= data_addr;
          r_wdata <= data_wdata;
        end else begin
          r_wr    <= 1'b0;
          r_wstrb <= '0;
          r_addr  <= inst_addr;
          r_wdata <= '0;
        end
      end
      if (w_state_next == StIdle) begin
        r_cancelled <= 1'b0;
      end else if (inst_cancel && (r_owner == OwnInst) && (r_state != StIdle)) begin
        r_cancelled <= 1'b1;
      end
    end
  end

endmodule
